regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 97 +++++++++
 tb/tb_regfile.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// 31x32 register file with per-register in-flight write scoreboard; reads are combinational
// with write-back bypass (zero latency); rdy_in low freezes data and counters, no backpressure out.
module regfile (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [4:0]  wb_reg_addr,
    input  logic [31:0] wb_reg_data,
    input  logic        wb_write,
    input  logic        issue_en,
    input  logic [4:0]  issue_addr,
    input  logic        flush_in,
    input  logic        read1_en,
    input  logic [4:0]  read1_addr,
    output logic [31:0] read1_data,
    output logic        read1_busy,
    input  logic        read2_en,
    input  logic [4:0]  read2_addr,
    output logic [31:0] read2_data,
    output logic        read2_busy
);

    // Entry 0 exists only to keep indexing uniform; it is never written.
    logic [31:0] r_regs [0:31];
    logic [1:0]  r_pend [0:31];

    logic        w_wb_vld;
    logic        w_issue_vld;
    logic [31:0] w_inc;
    logic [31:0] w_dec;

    assign w_wb_vld    = wb_write && (wb_reg_addr != 5'd0);
    assign w_issue_vld = issue_en && (issue_addr != 5'd0) && !flush_in;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_issue_vld) w_inc[issue_addr] = 1'b1;
        if (w_wb_vld)    w_dec[wb_reg_addr] = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (rdy_in && w_wb_vld) begin
            r_regs[wb_reg_addr] <= wb_reg_data;
        end
    end

    // Simultaneous issue and write-back to one register cancel out; both ends saturate.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) r_pend[i] <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                for (int i = 0; i < 32; i++) r_pend[i] <= '0;
            end else begin
                for (int i = 1; i < 32; i++) begin
                    case ({w_inc[i], w_dec[i]})
                        2'b10: if (r_pend[i] != 2'd3) r_pend[i] <= r_pend[i] + 2'd1;
                        2'b01: if (r_pend[i] != 2'd0) r_pend[i] <= r_pend[i] - 2'd1;
                        default: r_pend[i] <= r_pend[i];
                    endcase
                end
            end
        end
    end

    always_comb begin
        read1_data = '0;
        read1_busy = 1'b0;
        if (rst_in && read1_en && (read1_addr != 5'd0)) begin
            if (w_wb_vld && (wb_reg_addr == read1_addr)) begin
                read1_data = wb_reg_data;
                read1_busy = (r_pend[read1_addr] > 2'd1);
            end else begin
                read1_data = r_regs[read1_addr];
                read1_busy = (r_pend[read1_addr] != 2'd0);
            end
        end
    end

    always_comb begin
        read2_data = '0;
        read2_busy = 1'b0;
        if (rst_in && read2_en && (read2_addr != 5'd0)) begin
            if (w_wb_vld && (wb_reg_addr == read2_addr)) begin
                read2_data = wb_reg_data;
                read2_busy = (r_pend[read2_addr] > 2'd1);
            end else begin
                read2_data = r_regs[read2_addr];
                read2_busy = (r_pend[read2_addr] != 2'd0);
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: expectations queued as stimulus is driven, checked at the falling edge.
module tb_regfile;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_reg_data;
    logic        wb_write;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        flush_in;
    logic        read1_en, read2_en;
    logic [4:0]  read1_addr, read2_addr;
    logic [31:0] read1_data, read2_data;
    logic        read1_busy, read2_busy;

    regfile dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .wb_reg_addr (wb_reg_addr),
        .wb_reg_data (wb_reg_data),
        .wb_write    (wb_write),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .flush_in    (flush_in),
        .read1_en    (read1_en),
        .read1_addr  (read1_addr),
        .read1_data  (read1_data),
        .read1_busy  (read1_busy),
        .read2_en    (read2_en),
        .read2_addr  (read2_addr),
        .read2_data  (read2_data),
        .read2_busy  (read2_busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] d;
        logic        b;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic expect_rd(input int port, input string tag, input logic [31:0] d, input logic b);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.d    = d;
        e.b    = b;
        q.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] ad;
        logic        ab;
        @(negedge clk_in);
        while (q.size() > 0) begin
            e  = q.pop_front();
            ad = (e.port == 1) ? read1_data : read2_data;
            ab = (e.port == 1) ? read1_busy : read2_busy;
            n_cmp++;
            assert (ad === e.d) else begin
                n_fail++;
                $error("FAIL %s data: got %08h expected %08h", e.tag, ad, e.d);
            end
            n_cmp++;
            assert (ab === e.b) else begin
                n_fail++;
                $error("FAIL %s busy: got %0b expected %0b", e.tag, ab, e.b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clr();
        wb_write = 1'b0;
        issue_en = 1'b0;
        flush_in = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_write    = 1'b1;
        wb_reg_addr = a;
        wb_reg_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        issue_en   = 1'b1;
        issue_addr = a;
    endtask

    task automatic rd(input int port, input logic en, input logic [4:0] a);
        if (port == 1) begin
            read1_en   = en;
            read1_addr = a;
        end else begin
            read2_en   = en;
            read2_addr = a;
        end
    endtask

    initial begin
        // Reset held with every other input active: outputs must stay 0.
        rst_in = 1'b0;
        rdy_in = 1'b0;
        flush_in = 1'b0;
        wb(5'd1, 32'h000000AA);
        iss(5'd1);
        rd(1, 1'b1, 5'd1);
        rd(2, 1'b1, 5'd1);
        expect_rd(1, "rst_r1", 32'h0, 1'b0);
        expect_rd(2, "rst_r2", 32'h0, 1'b0);
        check();
        tick();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        clr();
        expect_rd(1, "post_rst", 32'h0, 1'b0);
        check();

        // Write then read on both ports; decrement at 0 must not wrap.
        wb(5'd5, 32'hDEADBEEF);
        tick();
        clr();
        rd(1, 1'b1, 5'd5);
        rd(2, 1'b1, 5'd5);
        expect_rd(1, "wr_rd_p1", 32'hDEADBEEF, 1'b0);
        expect_rd(2, "wr_rd_p2", 32'hDEADBEEF, 1'b0);
        check();

        // Bypass while the array still holds the old value (rdy low blocks the write).
        wb(5'd7, 32'h11111111);
        tick();
        wb(5'd7, 32'h12345678);
        rdy_in = 1'b0;
        rd(2, 1'b1, 5'd7);
        rd(1, 1'b0, 5'd7);
        expect_rd(2, "byp7", 32'h12345678, 1'b0);
        expect_rd(1, "dis_p1", 32'h0, 1'b0);
        check();
        tick();
        clr();
        rdy_in = 1'b1;
        expect_rd(2, "old7", 32'h11111111, 1'b0);
        check();
        wb(5'd7, 32'h12345678);
        tick();
        clr();
        expect_rd(2, "new7", 32'h12345678, 1'b0);
        check();

        // x0 ignores writes and issues.
        wb(5'd0, 32'hFFFFFFFF);
        iss(5'd0);
        rd(1, 1'b1, 5'd0);
        rd(2, 1'b1, 5'd0);
        expect_rd(1, "x0_same_p1", 32'h0, 1'b0);
        expect_rd(2, "x0_same_p2", 32'h0, 1'b0);
        check();
        tick();
        clr();
        expect_rd(1, "x0_after_p1", 32'h0, 1'b0);
        expect_rd(2, "x0_after_p2", 32'h0, 1'b0);
        check();

        // Scoreboard: three issues, a saturating fourth, then three write-backs.
        rd(1, 1'b1, 5'd3);
        rd(2, 1'b1, 5'd3);
        iss(5'd3);
        tick();
        expect_rd(1, "sb_p1", 32'h0, 1'b1);
        check();
        tick();
        tick();
        expect_rd(1, "sb_p3", 32'h0, 1'b1);
        check();
        tick();
        clr();
        wb(5'd3, 32'h00000033);
        tick();
        tick();
        clr();
        expect_rd(1, "sb_pend1", 32'h00000033, 1'b1);
        check();
        wb(5'd3, 32'h00003333);
        expect_rd(2, "sb_byp", 32'h00003333, 1'b0);
        check();
        tick();
        clr();
        expect_rd(1, "sb_done", 32'h00003333, 1'b0);
        check();

        // Simultaneous issue and write-back with one pending write.
        rd(1, 1'b1, 5'd9);
        iss(5'd9);
        tick();
        wb(5'd9, 32'h00000099);
        expect_rd(1, "cc_byp", 32'h00000099, 1'b0);
        check();
        tick();
        clr();
        expect_rd(1, "cc_pend", 32'h00000099, 1'b1);
        check();

        // Flush clears all counters and overrides issue; write-back still lands.
        iss(5'd4);
        tick();
        flush_in = 1'b1;
        iss(5'd4);
        wb(5'd10, 32'h0000A0A0);
        tick();
        clr();
        rd(2, 1'b1, 5'd4);
        expect_rd(1, "fl_x9", 32'h00000099, 1'b0);
        expect_rd(2, "fl_x4", 32'h0, 1'b0);
        check();
        rd(2, 1'b1, 5'd10);
        expect_rd(2, "fl_wb", 32'h0000A0A0, 1'b0);
        check();

        // rdy low freezes both data and counters.
        rdy_in = 1'b0;
        wb(5'd2, 32'h00000005);
        iss(5'd2);
        tick();
        clr();
        rdy_in = 1'b1;
        rd(2, 1'b1, 5'd2);
        expect_rd(2, "rdy_x2", 32'h0, 1'b0);
        check();

        // Mid-operation reset discards pending state and data.
        iss(5'd6);
        tick();
        clr();
        rd(1, 1'b1, 5'd6);
        expect_rd(1, "pre_rst_x6", 32'h0, 1'b1);
        check();
        rst_in = 1'b0;
        rdy_in = 1'b0;
        wb(5'd11, 32'h000000BB);
        iss(5'd6);
        rd(2, 1'b1, 5'd5);
        expect_rd(1, "in_rst_p1", 32'h0, 1'b0);
        expect_rd(2, "in_rst_p2", 32'h0, 1'b0);
        check();
        tick();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        clr();
        expect_rd(1, "rst_x6", 32'h0, 1'b0);
        expect_rd(2, "rst_x5", 32'h0, 1'b0);
        check();
        rd(2, 1'b1, 5'd11);
        expect_rd(2, "rst_x11", 32'h0, 1'b0);
        check();

        // First edge after reset behaves normally.
        wb(5'd12, 32'h0000000C);
        tick();
        clr();
        rd(1, 1'b1, 5'd12);
        rd(2, 1'b1, 5'd10);
        expect_rd(1, "post_x12", 32'h0000000C, 1'b0);
        expect_rd(2, "post_x10", 32'h0, 1'b0);
        check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
